button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 6000: consecutive stable synchronized samples needed to accept a level change; legal range >= 1.
REQ-002 Parameter REPEAT_DELAY, default 300000: cycles from press-step to first auto-repeat step; legal range >= 1.
REQ-003 Parameter REPEAT_RATE, default 60000: cycles between subsequent auto-repeat steps; legal range >= 1.
REQ-004 clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-007 pressed  output  1  debounced button level.
REQ-008 press  output  1  one-cycle pulse on debounced 0->1.
REQ-009 release  output  1  one-cycle pulse on debounced 1->0.
REQ-010 step  output  1  one-cycle pulse per paddle move: on press, then auto-repeat while held; drives paddle up/down.

Function
REQ-011 btn passes a 2-flop synchronizer; only the second flop's output (sync) is used downstream.
REQ-012 Debounce counter clears on any cycle where sync == pressed, and increments on any cycle where sync != pressed.
REQ-013 pressed toggles on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-014 Latency: btn stable from edge E0 onward -> pressed changes at edge E0+1+DEBOUNCE_CYCLES.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized samples does not change pressed or pulse any output.
REQ-016 press and release are registered, asserted for exactly the one cycle after the edge on which pressed changes, and are never high together.
REQ-017 Repeat FSM states: IDLE, DELAY, REPEAT; encoding 2 bits, local to the module.
REQ-018 IDLE: on the pressed 0->1 edge, assert step coincident with press, load the repeat counter, and go to DELAY.
REQ-019 DELAY: count REPEAT_DELAY cycles after the press step; on expiry, pulse step, reload with REPEAT_RATE, and go to REPEAT.
REQ-020 REPEAT: pulse step every REPEAT_RATE cycles while pressed = 1.
REQ-021 Any state: on the pressed 1->0 edge, go to IDLE and clear the repeat counter; step is not pulsed on that edge.
REQ-022 Repeat expiry and release on the same edge: release wins; no step.
REQ-023 Counter widths are $clog2(param+1); counters never wrap and never exceed their terminal value.
REQ-024 step is never high on two consecutive cycles.

Reset
REQ-025 While reset is high: synchronizer flops, debounce counter, and repeat counter = 0; FSM = IDLE; pressed, press, release, step = 0.
REQ-026 Reset mid-operation aborts any debounce or repeat in progress with no output pulse.
REQ-027 A button held through reset deassertion is treated as a fresh press: press and step follow after the full REQ-014 latency.

Structure
REQ-028 No shared package is required; parameters and FSM state codes stay local to the module.
REQ-029 The synchronizer is one sub-module, sync2 (1-bit, 2 flops, synchronous reset to 0), for reuse on BTN inputs by the pong top level.
REQ-030 Two instances (up, down) per paddle are instantiated in the pong top level; the block itself contains no paddle logic.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-031 btn rises before edge 0 and is held -> pressed, press, and step high at edge 5; press and step low at edge 6.
REQ-032 btn high for 3 cycles, then low -> pressed, press, and step never assert.
REQ-033 btn held 30 cycles after press at edge 5 -> step at edges 5, 15, 18, 21, 24, ... until release.
REQ-034 btn drops so that pressed falls at edge 18, coinciding with repeat expiry -> release high, step low at edge 18; FSM in IDLE.
REQ-035 Reset pulsed for 1 cycle at edge 12 while held -> all outputs 0; next press and step at edge 18 (12+1+4+1 sampling offset per REQ-014).
REQ-036 btn toggling every cycle for 50 cycles -> no output pulses; pressed stays 0.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared helpers for the button conditioner: counter sizing.
package button_conditioner_pkg;

   // Bits needed to hold 0..terminal without wrapping; never less than 1.
   function automatic int unsigned cnt_width(input int unsigned terminal);
      return (terminal < 1) ? 1 : $clog2(terminal + 1);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit, reset to 0.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop absorbs metastability; only the second flop is used downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronize, debounce, edge pulses and auto-repeat step.
// The release pulse is named release_pulse because "release" is a reserved word.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 6000,
   parameter int unsigned REPEAT_DELAY    = 300000,
   parameter int unsigned REPEAT_RATE     = 60000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pressed,
   output logic press,
   output logic release_pulse,
   output logic step
);

   localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RP_W   = cnt_width(RP_MAX);

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
   localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE);
   localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   logic            sync;
   logic [DB_W-1:0] db_cnt;
   logic            db_hit_c;
   logic            rise_c;
   logic            fall_c;

   rep_state_t      state;
   rep_state_t      state_nxt;
   logic [RP_W-1:0] rep_cnt;
   logic [RP_W-1:0] rep_cnt_nxt;
   logic            step_nxt;

   sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn),
      .q     (sync)
   );

   // Debounced level flips on the sample that would bring the count to its terminal value.
   assign db_hit_c = (sync != pressed) && (db_cnt == DB_LAST);
   assign rise_c   = db_hit_c & ~pressed;
   assign fall_c   = db_hit_c & pressed;

   // Debounce counter, debounced level and the registered edge pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt        <= '0;
         pressed       <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         if ((sync == pressed) || db_hit_c) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         if (db_hit_c) begin
            pressed <= ~pressed;
         end
         press         <= rise_c;
         release_pulse <= fall_c;
      end
   end

   // Repeat FSM state, down-counter and step register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rep_cnt <= '0;
         step    <= 1'b0;
      end else begin
         state   <= state_nxt;
         rep_cnt <= rep_cnt_nxt;
         step    <= step_nxt;
      end
   end

   // Next state: release overrides everything, including a same-edge repeat expiry.
   always_comb begin
      state_nxt   = state;
      rep_cnt_nxt = rep_cnt;
      step_nxt    = 1'b0;
      if (fall_c) begin
         state_nxt   = IDLE;
         rep_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise_c) begin
                  step_nxt    = 1'b1;
                  rep_cnt_nxt = RP_DELAY;
                  state_nxt   = DELAY;
               end
            end
            DELAY, REPEAT: begin
               if (rep_cnt <= RP_ONE) begin
                  step_nxt    = 1'b1;
                  rep_cnt_nxt = RP_RATE;
                  state_nxt   = REPEAT;
               end else begin
                  rep_cnt_nxt = rep_cnt - RP_ONE;
               end
            end
            default: begin
               state_nxt   = IDLE;
               rep_cnt_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_button_conditioner;

   localparam logic [3:0] PRESS_V = 4'b1101; // {pressed, press, release, step}
   localparam logic [3:0] STEP_V  = 4'b1001;
   localparam logic [3:0] REL_V   = 4'b0010;
   localparam logic [3:0] ZERO_V  = 4'b0000;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   logic clk;
   logic reset;
   logic btn;
   logic pressed;
   logic press;
   logic release_pulse;
   logic step;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   base      = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   logic exp_pressed = 1'b0;

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn),
      .pressed       (pressed),
      .press         (press),
      .release_pulse (release_pulse),
      .step          (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Queue an expected output vector at edge base+rel.
   task automatic expect_at(input int rel, input logic [3:0] v);
      exp_t e;
      e.cyc = base + rel;
      e.vec = v;
      exp_q.push_back(e);
   endtask

   // Run n edges, comparing outputs #1 after each edge against the scoreboard.
   task automatic run_check(input int n);
      exp_t       e;
      logic [3:0] expv;
      logic [3:0] obs;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         expv = {exp_pressed, 3'b000};
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e           = exp_q.pop_front();
            expv        = e.vec;
            exp_pressed = e.vec[3];
         end
         obs = {pressed, press, release_pulse, step};
         n_checks++;
         assert (obs === expv) else begin
            n_fail++;
            $error("FAIL outputs@%0d: observed %b expected %b", cyc, obs, expv);
         end
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b1;
      btn   = 1'b0;
      run_check(3);
      reset = 1'b0;
      run_check(3);

      // Held press: press+step at 5, repeats at 15,18,...
      base = cyc;
      btn  = 1'b1;
      expect_at(5, PRESS_V);
      for (int s = 15; s <= 33; s += 3) expect_at(s, STEP_V);
      run_check(35);
      // Release: repeats at old 36 and 39 still land, release at +5.
      base = cyc;
      btn  = 1'b0;
      expect_at(1, STEP_V);
      expect_at(4, STEP_V);
      expect_at(5, REL_V);
      run_check(10);

      // Three-cycle glitch: nothing happens.
      base = cyc;
      btn  = 1'b1;
      run_check(3);
      btn  = 1'b0;
      run_check(10);

      // Release coincides with repeat expiry at 18: release wins, no step.
      base = cyc;
      btn  = 1'b1;
      expect_at(5, PRESS_V);
      expect_at(15, STEP_V);
      expect_at(18, REL_V);
      run_check(13);
      btn  = 1'b0;
      run_check(12);

      // Reset at edge 12 while held; fresh press at 18.
      base = cyc;
      btn  = 1'b1;
      expect_at(5, PRESS_V);
      expect_at(12, ZERO_V);
      expect_at(18, PRESS_V);
      expect_at(28, STEP_V);
      expect_at(31, STEP_V);
      expect_at(33, REL_V);
      run_check(12);
      reset = 1'b1;
      run_check(1);
      reset = 1'b0;
      run_check(15);
      btn  = 1'b0;
      run_check(10);

      // Toggle every cycle: no pulses, pressed stays 0.
      run_check(3);
      for (int t = 0; t < 50; t++) begin
         btn = ~btn;
         run_check(1);
      end
      btn = 1'b0;
      run_check(8);

      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
